// File: rtl/muldiv_pkg.sv
// Shared constants for the iterative multiply/divide unit: funct3 encodings,
// FSM state codes, operation classes used by the result-reuse entry.
package muldiv_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    typedef enum logic [2:0] {
        CLS_MUL_SS,
        CLS_MUL_SU,
        CLS_MUL_UU,
        CLS_DIV_S,
        CLS_DIV_U
    } op_class_e;

    // MUL is computed signed x signed; its low half is identical for every class.
    function automatic op_class_e op_class(input logic [2:0] op);
        case (op)
            OP_MUL, OP_MULH: return CLS_MUL_SS;
            OP_MULHSU:       return CLS_MUL_SU;
            OP_MULHU:        return CLS_MUL_UU;
            OP_DIV, OP_REM:  return CLS_DIV_S;
            default:         return CLS_DIV_U;
        endcase
    endfunction

    function automatic logic signed_a(input logic [2:0] op);
        return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
               (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic signed_b(input logic [2:0] op);
        return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Pipeline-side bundle of the multiply/divide unit (start/busy/done handshake).
// Handshake: start is taken on a rising edge only while busy=0 and flush=0;
// muldiv_done pulses for one cycle with R valid in that same cycle.
interface muldiv_if #(parameter int XLEN = 32);
    logic            start;
    logic [2:0]      op;
    logic [XLEN-1:0] in_A;
    logic [XLEN-1:0] in_B;
    logic            flush;
    logic            busy;
    logic [XLEN-1:0] R;
    logic            muldiv_done;
    logic [1:0]      dbg_state;

    modport master (
        output start, op, in_A, in_B, flush,
        input  busy, R, muldiv_done, dbg_state
    );

    modport slave (
        input  start, op, in_A, in_B, flush,
        output busy, R, muldiv_done, dbg_state
    );
endinterface

// File: rtl/muldiv_iter.sv
// Shared datapath: one XLEN+1-bit adder/subtractor and a 2*XLEN shift register,
// stepping either shift-add multiply or restoring division one bit per cycle.
module muldiv_iter #(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              step,
    input  logic              is_div,
    input  logic [XLEN-1:0]   init_lo,
    input  logic [XLEN-1:0]   opnd,
    output logic [2*XLEN-1:0] acc
);
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   m_q, m_d;
    logic [XLEN:0]     add_a, add_r;

    always_comb begin
        m_d   = m_q;
        acc_d = acc_q;
        // Division works on the remainder shifted left with the next dividend bit.
        add_a = is_div ? acc_q[2*XLEN-1:XLEN-1] : {1'b0, acc_q[2*XLEN-1:XLEN]};
        add_r = is_div ? (add_a - {1'b0, m_q}) : (add_a + {1'b0, m_q});
        if (load) begin
            m_d   = opnd;
            acc_d = {{XLEN{1'b0}}, init_lo};
        end else if (step) begin
            if (is_div) begin
                acc_d = add_r[XLEN] ? {add_a[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                    : {add_r[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
            end else begin
                acc_d = acc_q[0] ? {add_r, acc_q[XLEN-1:1]} : {1'b0, acc_q[2*XLEN-1:1]};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
            m_q   <= '0;
        end else begin
            acc_q <= acc_d;
            m_q   <= m_d;
        end
    end

    assign acc = acc_q;
endmodule

// File: rtl/muldiv_unit.sv
// RISC-V M-extension multiply/divide unit: FSM, special cases, sign fix-up.
// Define MULDIV_REUSE_EN to keep the last full-width result for 1-cycle reuse.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic     clk,
    input  logic     reset,
    muldiv_if.slave  s
);
    localparam int CW = $clog2(XLEN);

    logic [1:0]        state_q, state_d;
    logic [CW-1:0]     count_q, count_d;
    logic [2:0]        op_q, op_d;
    logic              sa_q, sa_d, sb_q, sb_d;
    logic [XLEN-1:0]   r_q, r_d;
    logic              accept, special, hit, start_calc, load, step, in_sa, in_sb;
    logic              div_zero, div_ovf;
    logic [XLEN-1:0]   special_r, hit_r, a_mag, b_mag, quot_fix, rem_fix, fix_r;
    logic [2*XLEN-1:0] acc, prod_fix;

    assign accept = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && s.start && !s.flush;

    assign div_zero = s.op[2] && (s.in_B == '0);
    assign div_ovf  = ((s.op == OP_DIV) || (s.op == OP_REM)) &&
                      (s.in_A == {1'b1, {(XLEN-1){1'b0}}}) && (s.in_B == '1);
    assign special   = div_zero || div_ovf;
    assign special_r = div_zero ? (s.op[1] ? s.in_A : '1) : (s.op[1] ? '0 : s.in_A);
    assign start_calc = accept && !special && !hit;

    assign in_sa = signed_a(s.op) && s.in_A[XLEN-1];
    assign in_sb = signed_b(s.op) && s.in_B[XLEN-1];
    assign a_mag = in_sa ? -s.in_A : s.in_A;
    assign b_mag = in_sb ? -s.in_B : s.in_B;

    muldiv_iter #(.XLEN(XLEN)) u_iter (
        .clk     (clk),
        .rst     (reset),
        .load    (load),
        .step    (step),
        .is_div  (op_q[2]),
        .init_lo (s.op[2] ? a_mag : b_mag),
        .opnd    (s.op[2] ? b_mag : a_mag),
        .acc     (acc)
    );

    assign prod_fix = (sa_q ^ sb_q) ? -acc : acc;
    assign quot_fix = (sa_q ^ sb_q) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    assign rem_fix  = sa_q ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    assign fix_r    = op_q[2] ? (op_q[1] ? rem_fix : quot_fix)
                              : ((op_q == OP_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN]);

`ifdef MULDIV_REUSE_EN
    logic              rv_q, rv_d, same_ops;
    logic [XLEN-1:0]   ra_q, ra_d, rb_q, rb_d;
    logic [2*XLEN-1:0] rres_q, rres_d;
    op_class_e         rcls_q, rcls_d, in_cls;

    assign in_cls   = op_class(s.op);
    assign same_ops = rv_q && (s.in_A == ra_q) && (s.in_B == rb_q);

    always_comb begin
        if (s.op[2]) begin
            hit   = same_ops && (in_cls == rcls_q);
            hit_r = s.op[1] ? rres_q[2*XLEN-1:XLEN] : rres_q[XLEN-1:0];
        end else if (s.op == OP_MUL) begin
            hit   = same_ops && ((rcls_q == CLS_MUL_SS) || (rcls_q == CLS_MUL_SU) ||
                                 (rcls_q == CLS_MUL_UU));
            hit_r = rres_q[XLEN-1:0];
        end else begin
            hit   = same_ops && (in_cls == rcls_q);
            hit_r = rres_q[2*XLEN-1:XLEN];
        end
    end

    // Operands are captured at accept and the entry stays invalid until FIX fills it.
    always_comb begin
        rv_d   = rv_q;
        ra_d   = ra_q;
        rb_d   = rb_q;
        rcls_d = rcls_q;
        rres_d = rres_q;
        if (start_calc) begin
            rv_d   = 1'b0;
            ra_d   = s.in_A;
            rb_d   = s.in_B;
            rcls_d = in_cls;
        end
        if (state_q == ST_FIX) begin
            rv_d   = 1'b1;
            rres_d = op_q[2] ? {rem_fix, quot_fix} : prod_fix;
        end
        if (s.flush) rv_d = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rv_q   <= 1'b0;
            ra_q   <= '0;
            rb_q   <= '0;
            rcls_q <= CLS_MUL_SS;
            rres_q <= '0;
        end else begin
            rv_q   <= rv_d;
            ra_q   <= ra_d;
            rb_q   <= rb_d;
            rcls_q <= rcls_d;
            rres_q <= rres_d;
        end
    end
`else
    assign hit   = 1'b0;
    assign hit_r = '0;
`endif

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        op_d    = op_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        r_d     = r_q;
        load    = 1'b0;
        step    = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (accept) begin
                    op_d    = s.op;
                    sa_d    = in_sa;
                    sb_d    = in_sb;
                    count_d = '0;
                    if (special) begin
                        r_d     = special_r;
                        state_d = ST_DONE;
                    end else if (hit) begin
                        r_d     = hit_r;
                        state_d = ST_DONE;
                    end else begin
                        load    = 1'b1;
                        state_d = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                step    = 1'b1;
                count_d = count_q + 1'b1;
                if (count_q == CW'(XLEN-1)) begin
                    count_d = '0;
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                r_d     = fix_r;
                state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (s.flush) begin
            state_d = ST_IDLE;
            count_d = '0;
            r_d     = r_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            op_q    <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            r_q     <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            op_q    <= op_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            r_q     <= r_d;
        end
    end

    assign s.busy        = (state_q == ST_CALC) || (state_q == ST_FIX);
    assign s.R           = r_q;
    assign s.muldiv_done = (state_q == ST_DONE);
    assign s.dbg_state   = state_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit at XLEN=32; latency expectations follow the
// MULDIV_REUSE_EN setting of the build.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int LAT = 34;
`ifdef MULDIV_REUSE_EN
    localparam int HIT_LAT = 1;
`else
    localparam int HIT_LAT = 34;
`endif

    logic clk;
    logic reset;
    int   n_assert = 0;
    int   n_fail   = 0;
    logic [31:0] exp_q[$];

    muldiv_if #(.XLEN(32)) bus ();

    muldiv_unit #(.XLEN(32)) dut (
        .clk   (clk),
        .reset (reset),
        .s     (bus.slave)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issues one operation at a negedge (cycle 0) and waits for muldiv_done.
    task automatic do_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_r, input int exp_lat);
        int cyc;
        exp_q.push_back(exp_r);
        bus.op    = o;
        bus.in_A  = a;
        bus.in_B  = b;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.in_A  = $urandom;
        bus.in_B  = $urandom;
        bus.op    = 3'($urandom_range(0, 7));
        cyc = 1;
        while (!bus.muldiv_done && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_done"}, 32'(bus.muldiv_done), 32'd1);
        chk({tag, "_lat"}, 32'(cyc), 32'(exp_lat));
        chk({tag, "_R"}, bus.R, exp_q[0]);
        @(negedge clk);
        chk({tag, "_pulse"}, 32'(bus.muldiv_done), 32'd0);
        chk({tag, "_hold"}, bus.R, exp_q.pop_front());
    endtask

    initial begin
        int cyc;
        logic seen;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        bus.op    = 3'd0;
        bus.in_A  = '0;
        bus.in_B  = '0;
        reset     = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_R", bus.R, 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.muldiv_done), 32'd0);
        chk("rst_state", 32'(bus.dbg_state), 32'(ST_IDLE));

        do_op("mulhu_ff", OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, LAT);
        do_op("mul_ff", OP_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, HIT_LAT);
        do_op("mulh_neg", OP_MULH, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, LAT);
        do_op("mulhsu", OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, LAT);
        do_op("div_neg", OP_DIV, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, LAT);
        do_op("rem_neg", OP_REM, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, HIT_LAT);
        do_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd14, LAT);
        do_op("remu_100_7", OP_REMU, 32'd100, 32'd7, 32'd2, HIT_LAT);
        do_op("divu_by0", OP_DIVU, 32'd7, 32'd0, 32'hFFFFFFFF, 1);
        do_op("rem_by0", OP_REM, 32'd7, 32'd0, 32'd7, 1);
        do_op("div_ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
        do_op("rem_ovf", OP_REM, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1);
        do_op("divu_again", OP_DIVU, 32'd100, 32'd7, 32'd14, HIT_LAT);

        // Flush in cycle 10 with start held high through it
        bus.op    = OP_MULHU;
        bus.in_A  = 32'h80000000;
        bus.in_B  = 32'd6;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        cyc  = 1;
        seen = 1'b0;
        while (cyc < 10) begin
            if (bus.muldiv_done) seen = 1'b1;
            @(negedge clk);
            cyc++;
        end
        chk("fl_busy10", 32'(bus.busy), 32'd1);
        bus.flush = 1'b1;
        bus.start = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        chk("fl_state11", 32'(bus.dbg_state), 32'(ST_IDLE));
        chk("fl_busy11", 32'(bus.busy), 32'd0);
        chk("fl_nodone", 32'(seen | bus.muldiv_done), 32'd0);
        chk("fl_R_kept", bus.R, 32'd14);
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 12;
        while (!bus.muldiv_done && cyc < 150) begin
            @(negedge clk);
            cyc++;
        end
        chk("fl_re_done", 32'(bus.muldiv_done), 32'd1);
        chk("fl_re_lat", 32'(cyc), 32'd45);
        chk("fl_re_R", bus.R, 32'd3);
        @(negedge clk);

        // Asynchronous reset in cycle 5 of a DIV
        bus.op    = OP_DIV;
        bus.in_A  = 32'hFFFFFFF9;
        bus.in_B  = 32'd3;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        chk("ar_busy_pre", 32'(bus.busy), 32'd1);
        reset = 1'b1;
        #1;
        chk("ar_R", bus.R, 32'h0);
        chk("ar_busy", 32'(bus.busy), 32'd0);
        chk("ar_done", 32'(bus.muldiv_done), 32'd0);
        chk("ar_state", 32'(bus.dbg_state), 32'(ST_IDLE));
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        do_op("div_after_rst", OP_DIV, 32'hFFFFFFF9, 32'd3, 32'hFFFFFFFE, LAT);
        do_op("rem_after_rst", OP_REM, 32'hFFFFFFF9, 32'd3, 32'hFFFFFFFF, HIT_LAT);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised iterative multiply/divide unit implementing all eight RISC-V M-extension operations for an XLEN-bit core. It sits beside the ALU in the execute stage and talks to the pipeline through a start/busy/done handshake. It adds over the previous generation:
- width generalisation;
- single-cycle special-case handling;
- a flush input;
- optional reuse of the previous full-width result.

## Interface
- XLEN, 32, operand/result width; any even value ≥ 8
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  request; accepted only in a cycle where busy=0
- op  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- in_A  in  XLEN  rs1 operand (multiplicand / dividend); sampled on the accepting edge
- in_B  in  XLEN  rs2 operand (multiplier / divisor); sampled on the accepting edge
- flush  in  1  synchronous abort of the operation in flight
- busy  out  1  operation in flight; start is ignored while high
- R  out  XLEN  result, registered; holds until the next muldiv_done
- muldiv_done  out  1  one-cycle pulse; R is valid in the same cycle

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE/DONE + start:
  - special case or reuse hit -> DONE;
  - otherwise -> CALC with count=0.
- CALC: one iteration per cycle; count increments; -> FIX when count = XLEN-1.
- FIX: applies sign correction and selects the output half; loads R -> DONE.
- DONE: muldiv_done=1 for one cycle -> IDLE unless start is accepted in that cycle.
- busy=1 in CALC and FIX only, so back-to-back starts are accepted in DONE.
- Signed operands are converted to magnitude on entry. Result sign:
  - MULH: sign(A) xor sign(B); MULHSU: sign(A);
  - DIV quotient: sign(A) xor sign(B); REM remainder: sign(A).
- Multiply: shift-add over a 2·XLEN-bit product.
  - MUL returns the low XLEN bits; MULH/MULHSU/MULHU return the high XLEN bits.
- Divide: restoring, one quotient bit per cycle, XLEN+1-bit subtractor.
- Special cases, all resolved without CALC:
  - divide by zero: DIV/DIVU R = all ones; REM/REMU R = in_A;
  - signed overflow (DIV/REM, A = 1<<(XLEN-1), B = all ones): DIV R = in_A; REM R = 0.
- flush in any state: -> IDLE on the next edge; no muldiv_done; R keeps its old value.
- flush and start in the same cycle: flush wins and start is dropped.
- reset: state IDLE, R=0, busy=0, muldiv_done=0, counter 0, reuse entry invalid.
- reset mid-operation: same values, immediately (asynchronous).

## Timing
- Normal latency: start high in cycle 0; CALC cycles 1..XLEN; FIX cycle XLEN+1; muldiv_done in cycle XLEN+2 (cycle 34 at XLEN=32).
- Special case or reuse hit: muldiv_done in cycle 1.
- Throughput: one normal operation per XLEN+2 cycles.
- in_A, in_B and op may change after the accepting edge.

## Configuration
- MULDIV_REUSE_EN defined:
  - Stores the last in_A, in_B, class and full result: 2·XLEN product, or quotient plus remainder.
  - Class is multiply-ss, multiply-su, multiply-uu, divide-signed or divide-unsigned.
  - Hit (1-cycle latency) cases:
    - MUL with equal operands and any multiply class;
    - MULH/MULHSU/MULHU with equal operands and the same class;
    - DIV↔REM or DIVU↔REMU with equal operands and the same signedness.
  - The entry is written in FIX.
  - Invalidated by flush and reset; special cases neither hit nor write it.
- MULDIV_REUSE_EN undefined: no storage; every non-special operation takes XLEN+2 cycles.

## Structure
- Package muldiv_pkg: op encoding constants, state enum, class enum, default XLEN.
- Sub-module muldiv_iter holds the shared datapath:
  - one XLEN+1-bit adder/subtractor and the 2·XLEN accumulator/shift register;
  - used for both multiply (add) and divide (trial subtract).
- The top level holds the FSM, counter, sign fix-up, special-case decode and the reuse entry.

## Test plan
All cases use XLEN=32.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF -> R=0xFFFFFFFE; done in cycle 34. Then MUL same operands -> 0x00000001; cycle 1 with REUSE_EN, cycle 34 without.
- MULH 0xFFFFFFFE × 0x00000003 -> 0xFFFFFFFF. MULHSU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; then REM same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14; REMU -> 2.
- DIVU 7/0 -> 0xFFFFFFFF in cycle 1; REM 7/0 -> 7. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 in cycle 1; REM -> 0.
- flush in cycle 10 of a MULHU -> no done, IDLE in cycle 11, R unchanged. A start held high through that flush cycle is dropped; the same start in cycle 11 is accepted with done in cycle 45.
- Assert reset in cycle 5 of a DIV -> R=0, busy=0, done=0 immediately. The next identical DIV takes the full 34 cycles (reuse entry invalid).
